// File: rtl/csr_file_pkg.sv
// csr_file_pkg: shared definitions for the machine-mode CSR file.
//   - DATA_WIDTH define (CSR data path width)
//   - CSR address map, mstatus/mie/mip bit positions and write masks
//   - helpers for write-side masking and writability
// Optional feature macro: CSR_COUNTERS_EN (mcycle/minstret and shadows).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package csr_file_pkg;

  typedef enum logic [11:0] {
    CSR_MSTATUS   = 12'h300,
    CSR_MIE       = 12'h304,
    CSR_MTVEC     = 12'h305,
    CSR_MSCRATCH  = 12'h340,
    CSR_MEPC      = 12'h341,
    CSR_MCAUSE    = 12'h342,
    CSR_MIP       = 12'h344,
    CSR_MCYCLE    = 12'hB00,
    CSR_MINSTRET  = 12'hB02,
    CSR_MCYCLEH   = 12'hB80,
    CSR_MINSTRETH = 12'hB82,
    CSR_CYCLE     = 12'hC00,
    CSR_INSTRET   = 12'hC02,
    CSR_CYCLEH    = 12'hC80,
    CSR_INSTRETH  = 12'hC82,
    CSR_MHARTID   = 12'hF14
  } csr_addr_e;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned IRQ_SW_BIT       = 3;
  localparam int unsigned IRQ_TIMER_BIT    = 7;
  localparam int unsigned IRQ_EXT_BIT      = 11;

  // MPP is hardwired to machine mode (2'b11 in bits 12:11).
  localparam logic [31:0] MSTATUS_MPP_M = 32'h0000_1800;
  localparam logic [31:0] MSTATUS_MASK  = 32'h0000_0088;
  localparam logic [31:0] IRQ_MASK      = 32'h0000_0888;
  localparam logic [31:0] MEPC_MASK     = 32'hFFFF_FFFC;

  function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
    logic [31:0] v;
    v = MSTATUS_MPP_M;
    v[MSTATUS_MIE_BIT]  = mie;
    v[MSTATUS_MPIE_BIT] = mpie;
    return v;
  endfunction

  // Value a WB write to addr would commit (as it reads back).
  function automatic logic [31:0] csr_write_mask(input logic [11:0] addr,
                                                 input logic [31:0] data);
    case (addr)
      CSR_MSTATUS: return (data & MSTATUS_MASK) | MSTATUS_MPP_M;
      CSR_MIE:     return data & IRQ_MASK;
      CSR_MEPC:    return data & MEPC_MASK;
      default:     return data;
    endcase
  endfunction

  function automatic logic csr_writable(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE:
        return 1'b1;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH:
        return 1'b1;
`endif
      default:
        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// csr_counter64: 64-bit counter split into two 32-bit halves.
//   clk_i/rst_i  clock, async active-high reset
//   inc_i        increment enable
//   we_lo_i/we_hi_i  per-half write enable (wins over that half's increment)
//   wdata_i      write data for either half
//   value_o      current 64-bit value
// Only built when CSR_COUNTERS_EN is defined, so the default build carries
// no counter flops and no orphan module.
`ifdef CSR_COUNTERS_EN
module csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        we_lo_i,
  input  logic        we_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] value_o
);

  logic [31:0] lo_q;
  logic [31:0] hi_q;
  logic [32:0] lo_sum;

  assign lo_sum  = {1'b0, lo_q} + {32'd0, inc_i};
  assign value_o = {hi_q, lo_q};

  // Carry comes from the pre-write low half, so the upper half still
  // advances even when the low half is being overwritten.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= we_lo_i ? wdata_i : lo_sum[31:0];
      hi_q <= we_hi_i ? wdata_i : hi_q + {31'd0, lo_sum[32]};
    end
  end

endmodule
`endif

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file at the end of the writeback path.
//   clk_i, rst_i           clock, async active-high reset
//   csr_we_i/waddr/wdata   WB write port (commits on the rising edge)
//   instret_incr_i         retire pulse
//   csr_raddr_i/rdata_o    combinational read port with write bypass
//   trap_i, trap_mepc_i, trap_mcause_i  trap entry from interrupt controller
//   mret_i                 mret strobe
//   irq_ext/timer/sw_i     level interrupt lines, registered into mip
//   mtvec_o, mepc_o, mie_o, mip_o, mstatus_mie_o  current state
// Optional feature macro: CSR_COUNTERS_EN (mcycle/minstret + read-only shadows).
module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   csr_we_i,
  input  logic [11:0]            csr_waddr_i,
  input  logic [`DATA_WIDTH-1:0] csr_wdata_i,
  input  logic                   instret_incr_i,
  input  logic [11:0]            csr_raddr_i,
  output logic [31:0]            csr_rdata_o,
  input  logic                   trap_i,
  input  logic [31:0]            trap_mepc_i,
  input  logic [31:0]            trap_mcause_i,
  input  logic                   mret_i,
  input  logic                   irq_ext_i,
  input  logic                   irq_timer_i,
  input  logic                   irq_sw_i,
  output logic [31:0]            mtvec_o,
  output logic [31:0]            mepc_o,
  output logic [31:0]            mie_o,
  output logic [31:0]            mip_o,
  output logic                   mstatus_mie_o
);

  logic        mstatus_mie_q;
  logic        mstatus_mpie_q;
  logic [31:0] mie_q;
  logic [31:0] mip_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;

  logic [31:0] wval;
  logic        wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause;
  logic [31:0] irq_now;
  logic [31:0] rdata_raw;

  assign wval        = csr_write_mask(csr_waddr_i, csr_wdata_i);
  assign wr_mstatus  = csr_we_i && (csr_waddr_i == CSR_MSTATUS);
  assign wr_mie      = csr_we_i && (csr_waddr_i == CSR_MIE);
  assign wr_mtvec    = csr_we_i && (csr_waddr_i == CSR_MTVEC);
  assign wr_mscratch = csr_we_i && (csr_waddr_i == CSR_MSCRATCH);
  assign wr_mepc     = csr_we_i && (csr_waddr_i == CSR_MEPC);
  assign wr_mcause   = csr_we_i && (csr_waddr_i == CSR_MCAUSE);

  always_comb begin
    irq_now                = '0;
    irq_now[IRQ_EXT_BIT]   = irq_ext_i;
    irq_now[IRQ_TIMER_BIT] = irq_timer_i;
    irq_now[IRQ_SW_BIT]    = irq_sw_i;
  end

  // Priority trap > mret > WB applies per field; untouched fields still
  // take the WB write in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mip_q          <= '0;
      mtvec_q        <= MTVEC_RESET;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
    end else begin
      mip_q <= irq_now;
      if (wr_mie)      mie_q      <= wval;
      if (wr_mtvec)    mtvec_q    <= wval;
      if (wr_mscratch) mscratch_q <= wval;
      if (trap_i) begin
        mepc_q         <= trap_mepc_i & MEPC_MASK;
        mcause_q       <= trap_mcause_i;
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end else begin
        if (wr_mepc)   mepc_q   <= wval;
        if (wr_mcause) mcause_q <= wval;
        if (mret_i) begin
          mstatus_mie_q  <= mstatus_mpie_q;
          mstatus_mpie_q <= 1'b1;
        end else if (wr_mstatus) begin
          mstatus_mie_q  <= wval[MSTATUS_MIE_BIT];
          mstatus_mpie_q <= wval[MSTATUS_MPIE_BIT];
        end
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q;
  logic [63:0] minstret_q;

  csr_counter64 u_mcycle (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (1'b1),
    .we_lo_i (csr_we_i && (csr_waddr_i == CSR_MCYCLE)),
    .we_hi_i (csr_we_i && (csr_waddr_i == CSR_MCYCLEH)),
    .wdata_i (csr_wdata_i),
    .value_o (mcycle_q)
  );

  csr_counter64 u_minstret (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (instret_incr_i),
    .we_lo_i (csr_we_i && (csr_waddr_i == CSR_MINSTRET)),
    .we_hi_i (csr_we_i && (csr_waddr_i == CSR_MINSTRETH)),
    .wdata_i (csr_wdata_i),
    .value_o (minstret_q)
  );
`else
  logic unused_instret;
  assign unused_instret = instret_incr_i;
`endif

  always_comb begin
    rdata_raw = '0;
    case (csr_raddr_i)
      CSR_MSTATUS:  rdata_raw = mstatus_pack(mstatus_mie_q, mstatus_mpie_q);
      CSR_MIE:      rdata_raw = mie_q;
      CSR_MTVEC:    rdata_raw = mtvec_q;
      CSR_MSCRATCH: rdata_raw = mscratch_q;
      CSR_MEPC:     rdata_raw = mepc_q;
      CSR_MCAUSE:   rdata_raw = mcause_q;
      CSR_MIP:      rdata_raw = mip_q;
      CSR_MHARTID:  rdata_raw = HART_ID;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE,   CSR_CYCLE:    rdata_raw = mcycle_q[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:   rdata_raw = mcycle_q[63:32];
      CSR_MINSTRET, CSR_INSTRET:  rdata_raw = minstret_q[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rdata_raw = minstret_q[63:32];
`endif
      default:      rdata_raw = '0;
    endcase
  end

  // Same-address WB write is forwarded so execute sees the committed value.
  assign csr_rdata_o = (csr_we_i && (csr_waddr_i == csr_raddr_i) && csr_writable(csr_waddr_i))
                       ? wval : rdata_raw;

  assign mtvec_o       = mtvec_q;
  assign mepc_o        = mepc_q;
  assign mie_o         = mie_q;
  assign mip_o         = mip_q;
  assign mstatus_mie_o = mstatus_mie_q;

endmodule
